// File: rtl/vertex_projector_if.sv
// Handshake bundle for vertex_projector.
//   master: producer side (drives matrix, vertex and out_ready; observes results)
//   slave : the projector itself
// Signals:
//   projection_matrix/mat_load : row-major 4x4 matrix, element (r,c) at 4*r+c, and its load strobe
//   in_valid/in_ready, in_x/y/z : object-space vertex handshake (w implied 1.0)
//   out_valid/out_ready, out_x/y/z/w, out_overflow : NDC result handshake plus clip-space w
//   busy : projector is not idle
interface vertex_projector_if #(
  parameter int unsigned WI = 8,
  parameter int unsigned WF = 8
);
  localparam int unsigned W = WI + WF;

  logic [15:0][W-1:0] projection_matrix;
  logic               mat_load;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_x;
  logic [W-1:0]       in_y;
  logic [W-1:0]       in_z;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_x;
  logic [W-1:0]       out_y;
  logic [W-1:0]       out_z;
  logic [W-1:0]       out_w;
  logic               out_overflow;
  logic               busy;

  modport master (
    output projection_matrix, mat_load, in_valid, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_w, out_overflow, busy
  );

  modport slave (
    input  projection_matrix, mat_load, in_valid, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_w, out_overflow, busy
  );
endinterface

// File: rtl/vertex_projector.sv
// Clip-space transform and perspective divide for one vertex at a time.
// A single multiplier accumulates the four clip rows over 16 cycles, the rows are rounded and
// saturated back to WI.WF, then a restoring divider forms x/w, y/w, z/w one bit per cycle.
// Ports:
//   clk  : clock
//   rstn : synchronous active-low reset (matrix returns to identity)
//   bus  : vertex_projector_if slave modport (matrix load, vertex in, NDC out, busy)
module vertex_projector #(
  parameter int unsigned WI = 8,
  parameter int unsigned WF = 8
) (
  input logic               clk,
  input logic               rstn,
  vertex_projector_if.slave bus
);
  localparam int unsigned W   = WI + WF;
  localparam int unsigned PW  = 2 * W;
  localparam int unsigned AW  = PW + 2;
  localparam int unsigned DW  = WI + 2 * WF;
  localparam int unsigned ItW = $clog2(DW);

  localparam logic [W-1:0]          One    = W'(1) << WF;
  localparam logic [W-1:0]          PosMax = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]          NegMax = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0]  Half   = AW'(1) << (WF - 1);
  localparam logic signed [AW-1:0]  AccMax = AW'(PosMax);
  localparam logic signed [AW-1:0]  AccMin = ~AccMax;
  localparam logic [ItW-1:0]        ItLast = ItW'(DW - 1);

  typedef enum logic [2:0] {StIdle, StMac, StNorm, StDiv, StDone} state_e;

  state_e                 state_q;
  logic [15:0][W-1:0]     mat_q;
  logic [2:0][W-1:0]      vtx_q;
  logic signed [AW-1:0]   acc_q [4];
  logic [3:0]             mac_cnt_q;
  logic [2:0][W-1:0]      clip_q;
  logic [1:0]             div_idx_q;
  logic [ItW-1:0]         div_it_q;
  logic [DW-1:0]          quo_q;
  logic [W-1:0]           rem_q;
  logic [2:0][W-1:0]      res_q;
  logic [W-1:0]           out_w_q;
  logic                   ovf_q;

  // Round half up, drop WF fraction bits, saturate. Returns {saturated, value}.
  function automatic logic [W:0] norm_acc(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] r;
    r = (a + Half) >>> WF;
    if (r > AccMax)      norm_acc = {1'b1, PosMax};
    else if (r < AccMin) norm_acc = {1'b1, NegMax};
    else                 norm_acc = {1'b0, r[W-1:0]};
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] a);
    mag = a[W-1] ? W'(~a + 1'b1) : a;
  endfunction

  // Apply sign and range limits to an unsigned quotient. Returns {overflow, value}.
  function automatic logic [W:0] div_final(input logic [DW-1:0] q, input logic num_neg,
                                           input logic den_neg, input logic den_zero);
    logic neg;
    neg = num_neg ^ den_neg;
    if (den_zero)  div_final = {1'b1, num_neg ? NegMax : PosMax};
    else if (!neg) div_final = (q > DW'(PosMax)) ? {1'b1, PosMax} : {1'b0, q[W-1:0]};
    else           div_final = (q > DW'(NegMax)) ? {1'b1, NegMax}
                                                 : {1'b0, W'(~q[W-1:0] + 1'b1)};
  endfunction

  // Shared multiplier: matrix element selected by the MAC counter times vertex component.
  logic [1:0]           mac_r;
  logic [1:0]           mac_c;
  logic signed [W-1:0]  m_op;
  logic signed [W-1:0]  v_op;
  logic signed [PW-1:0] prod;

  assign mac_r = mac_cnt_q[3:2];
  assign mac_c = mac_cnt_q[1:0];

  always_comb begin
    m_op = mat_q[mac_cnt_q];
    unique case (mac_c)
      2'd0:    v_op = vtx_q[0];
      2'd1:    v_op = vtx_q[1];
      2'd2:    v_op = vtx_q[2];
      default: v_op = One;
    endcase
    prod = m_op * v_op;
  end

  logic [3:0][W:0] norm_res;
  always_comb begin
    for (int i = 0; i < 4; i++) norm_res[i] = norm_acc(acc_q[i]);
  end

  // One restoring-division step; the dividend shifts out of quo_q as quotient bits shift in.
  logic [W-1:0]  dsr;
  logic [W:0]    rem_sh;
  logic [W-1:0]  rem_d;
  logic [DW-1:0] quo_d;
  logic [W:0]    fin;

  assign dsr = mag(out_w_q);

  always_comb begin
    rem_sh = {rem_q, quo_q[DW-1]};
    if (rem_sh >= {1'b0, dsr}) begin
      rem_d = W'(rem_sh - {1'b0, dsr});
      quo_d = {quo_q[DW-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[W-1:0];
      quo_d = {quo_q[DW-2:0], 1'b0};
    end
    fin = div_final(quo_d, clip_q[div_idx_q][W-1], out_w_q[W-1], out_w_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      for (int i = 0; i < 16; i++) mat_q[i] <= (i % 5 == 0) ? One : '0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
      vtx_q     <= '0;
      mac_cnt_q <= '0;
      clip_q    <= '0;
      div_idx_q <= '0;
      div_it_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      out_w_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A matrix load blocks acceptance, so a waiting vertex sees the new matrix.
          if (bus.mat_load) begin
            mat_q <= bus.projection_matrix;
          end else if (bus.in_valid) begin
            vtx_q <= {bus.in_z, bus.in_y, bus.in_x};
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
            mac_cnt_q <= '0;
            ovf_q     <= 1'b0;
            state_q   <= StMac;
          end
        end
        StMac: begin
          acc_q[mac_r] <= acc_q[mac_r] + {{2{prod[PW-1]}}, prod};
          mac_cnt_q    <= mac_cnt_q + 4'd1;
          if (mac_cnt_q == 4'd15) state_q <= StNorm;
        end
        StNorm: begin
          for (int i = 0; i < 3; i++) clip_q[i] <= norm_res[i][W-1:0];
          out_w_q   <= norm_res[3][W-1:0];
          ovf_q     <= norm_res[0][W] | norm_res[1][W] | norm_res[2][W] | norm_res[3][W];
          quo_q     <= {mag(norm_res[0][W-1:0]), {WF{1'b0}}};
          rem_q     <= '0;
          div_idx_q <= '0;
          div_it_q  <= '0;
          state_q   <= StDiv;
        end
        StDiv: begin
          if (div_it_q == ItLast) begin
            res_q[div_idx_q] <= fin[W-1:0];
            ovf_q            <= ovf_q | fin[W];
            div_it_q         <= '0;
            rem_q            <= '0;
            if (div_idx_q == 2'd2) begin
              state_q <= StDone;
            end else begin
              div_idx_q <= div_idx_q + 2'd1;
              quo_q     <= {mag(clip_q[div_idx_q + 2'd1]), {WF{1'b0}}};
            end
          end else begin
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            div_it_q <= div_it_q + ItW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == StIdle) && !bus.mat_load;
  assign bus.out_valid    = (state_q == StDone);
  assign bus.busy         = (state_q != StIdle);
  assign bus.out_x        = res_q[0];
  assign bus.out_y        = res_q[1];
  assign bus.out_z        = res_q[2];
  assign bus.out_w        = out_w_q;
  assign bus.out_overflow = ovf_q;
endmodule

// File: tb/tb_vertex_projector.sv
// Scoreboard bench for vertex_projector: the stimulus process pushes hand-computed results,
// a monitor pops and compares on every output handshake and checks the accept-to-valid latency.
module tb_vertex_projector;
  localparam int unsigned WI = 8;
  localparam int unsigned WF = 8;
  localparam int unsigned W  = WI + WF;

  typedef logic [15:0][W-1:0] mat_t;
  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [W-1:0] w;
    logic         ovf;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t sb[$];

  vertex_projector_if #(.WI(WI), .WF(WF)) bus ();

  vertex_projector #(.WI(WI), .WF(WF)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] z, input logic [W-1:0] w, input logic ovf);
    exp_t e;
    e.x = x; e.y = y; e.z = z; e.w = w; e.ovf = ovf;
    return e;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    m = '0;
    m[0] = 16'h0100; m[5] = 16'h0100; m[10] = 16'h0100; m[15] = 16'h0100;
    return m;
  endfunction

  // Monitor: latency on out_valid rise, result compare on handshake.
  initial begin
    exp_t e;
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.out_valid && !prev_valid) chk("latency", W'(cyc - acc_cyc), W'(90));
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got x=%h want none", bus.out_x);
          end else begin
            e = sb.pop_front();
            chk("out_x", bus.out_x, e.x);
            chk("out_y", bus.out_y, e.y);
            chk("out_z", bus.out_z, e.z);
            chk("out_w", bus.out_w, e.w);
            chk("out_overflow", W'(bus.out_overflow), W'(e.ovf));
          end
        end
        if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic load_matrix(input mat_t m);
    wait_idle();
    bus.projection_matrix = m;
    bus.mat_load = 1'b1;
    @(posedge clk); #1;
    bus.mat_load = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                      input exp_t e, input bit push);
    int  n;
    logic ok;
    if (push) sb.push_back(e);
    bus.in_x = x; bus.in_y = y; bus.in_z = z;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      n++;
    end while (!ok && n < 300);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    wait_idle();
  endtask

  initial begin
    mat_t m;
    int   n;
    bus.projection_matrix = ident();
    bus.mat_load  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_z      = '0;
    bus.out_ready = 1'b1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_overflow", W'(bus.out_overflow), W'(0));
    chk("rst_out_x", bus.out_x, 16'h0000);
    chk("rst_out_y", bus.out_y, 16'h0000);
    chk("rst_out_z", bus.out_z, 16'h0000);
    chk("rst_out_w", bus.out_w, 16'h0000);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Identity after reset.
    send(16'h0100, 16'h0200, 16'h0300, mk(16'h0100, 16'h0200, 16'h0300, 16'h0100, 1'b0), 1);
    drain();

    // Projection; matrix load and vertex presented together.
    m = '0;
    m[0] = 16'h0200; m[5] = 16'h0200; m[10] = 16'h0100; m[11] = 16'hFF00; m[14] = 16'h0100;
    wait_idle();
    sb.push_back(mk(16'h0100, 16'h0100, 16'h0080, 16'h0200, 1'b0));
    bus.projection_matrix = m;
    bus.mat_load = 1'b1;
    bus.in_x = 16'h0100; bus.in_y = 16'h0100; bus.in_z = 16'h0200;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("ready_during_load", W'(bus.in_ready), W'(0));
    @(posedge clk); #1;
    bus.mat_load = 1'b0;
    @(negedge clk);
    chk("ready_after_load", W'(bus.in_ready), W'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();

    // Divide by zero.
    m = '0;
    m[0] = 16'h0100;
    load_matrix(m);
    send(16'hFF00, 16'h0000, 16'h0000, mk(16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b1), 1);
    drain();

    // Saturation in NORM.
    m = ident();
    m[0] = 16'h7FFF;
    load_matrix(m);
    send(16'h7FFF, 16'h0000, 16'h0000, mk(16'h7FFF, 16'h0000, 16'h0000, 16'h0100, 1'b1), 1);
    drain();

    // Round half up on positive and negative half-LSB products.
    m = ident();
    m[0] = 16'h0180; m[5] = 16'h0180;
    load_matrix(m);
    send(16'h0001, 16'hFFFF, 16'h0000, mk(16'h0002, 16'hFFFF, 16'h0000, 16'h0100, 1'b0), 1);
    drain();

    // Non-exact quotients truncate toward zero.
    m = ident();
    m[15] = 16'h0300;
    load_matrix(m);
    send(16'h0100, 16'hFF00, 16'h0200, mk(16'h0055, 16'hFFAB, 16'h00AA, 16'h0300, 1'b0), 1);
    drain();

    // Negative w flips signs.
    m = ident();
    m[15] = 16'hFE00;
    load_matrix(m);
    send(16'h0100, 16'hFF00, 16'h0000, mk(16'hFF80, 16'h0080, 16'h0000, 16'hFE00, 1'b0), 1);
    drain();

    // Backpressure: result held 10 cycles, then next vertex accepted right after handshake.
    load_matrix(ident());
    bus.out_ready = 1'b0;
    send(16'h0100, 16'h0200, 16'h0300, mk(16'h0100, 16'h0200, 16'h0300, 16'h0100, 1'b0), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 200);
    chk("bp_valid_seen", W'(bus.out_valid), W'(1));
    @(posedge clk); #1;
    sb.push_back(mk(16'h0080, 16'h0000, 16'h0100, 16'h0100, 1'b0));
    bus.in_x = 16'h0080; bus.in_y = 16'h0000; bus.in_z = 16'h0100;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", W'(bus.out_valid), W'(1));
      chk("bp_in_ready", W'(bus.in_ready), W'(0));
      chk("bp_out_x", bus.out_x, 16'h0100);
      chk("bp_out_z", bus.out_z, 16'h0300);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("hs_in_ready", W'(bus.in_ready), W'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_hs_in_ready", W'(bus.in_ready), W'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("post_hs_busy", W'(bus.busy), W'(1));
    drain();

    // mat_load mid-MAC is ignored.
    m = ident();
    m[15] = 16'h0200;
    load_matrix(m);
    send(16'h0100, 16'h0200, 16'h0300, mk(16'h0080, 16'h0100, 16'h0180, 16'h0200, 1'b0), 1);
    repeat (39) @(posedge clk);
    #1;
    m = ident();
    m[0] = 16'h0400;
    bus.projection_matrix = m;
    bus.mat_load = 1'b1;
    @(posedge clk); #1;
    bus.mat_load = 1'b0;
    drain();
    send(16'h0200, 16'h0000, 16'h0000, mk(16'h0100, 16'h0000, 16'h0000, 16'h0200, 1'b0), 1);
    drain();

    // Reset mid-operation restores identity and idles immediately.
    send(16'h0100, 16'h0100, 16'h0100, mk(16'h0, 16'h0, 16'h0, 16'h0, 1'b0), 0);
    repeat (49) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", W'(bus.busy), W'(0));
    chk("midrst_out_valid", W'(bus.out_valid), W'(0));
    chk("midrst_in_ready", W'(bus.in_ready), W'(1));
    @(posedge clk); #1;
    rstn = 1'b1;
    send(16'h0100, 16'h0200, 16'h0300, mk(16'h0100, 16'h0200, 16'h0300, 16'h0100, 1'b0), 1);
    drain();

    chk("scoreboard_empty", W'(sb.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vertex_projector.md
# vertex_projector

Sequential clip-space transform and perspective-divide stage fed by the projection-matrix generator. It latches the 4x4 fixed-point projection matrix and accepts one object-space vertex (x, y, z, w=1) per handshake. A single shared multiplier forms the clip-space vector, and an iterative divider produces normalized device coordinates (NDC) for the rasterizer.

## Interface
- WI, 8, integer bits of every fixed-point value (matrix, vertex, outputs); signed two's complement
- WF, 8, fraction bits of every fixed-point value
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  synchronous, active-low reset
- projection_matrix  in  [15:0][WI+WF-1:0]  row-major matrix; element (r,c) at index 4*r+c
- mat_load  in  1  latch projection_matrix this cycle (honoured only in IDLE)
- in_valid  in  1  vertex present
- in_ready  out  1  vertex accepted when in_valid && in_ready
- in_x, in_y, in_z  in  WI+WF each  object-space vertex; w implied 1.0
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_x, out_y, out_z  out  WI+WF each  NDC = clip/clip_w
- out_w  out  WI+WF  clip-space w, passed through for the clipper
- out_overflow  out  1  saturation or divide-by-zero occurred for this vertex
- busy  out  1  state != IDLE

## Operation
- States: IDLE, MAC, NORM, DIV, DONE.
- **IDLE**
  - in_ready = !mat_load.
  - mat_load=1: matrix register <= projection_matrix; no vertex accepted that cycle.
  - Accept: latch vertex, clear accumulator and overflow flag, go MAC.
  - mat_load outside IDLE is ignored; the matrix stays stable for the whole vertex.
- **MAC**: 16 cycles, counter r,c = 0..3.
  - acc_r += m[4r+c] * v[c], where v = (x, y, z, 1.0 = 1<<WF).
  - Each product is full width 2(WI+WF). Each accumulator is 2(WI+WF)+2 bits, so no intermediate overflow.
- **NORM**: 1 cycle.
  - Each acc_r is reduced to WI+WF bits: drop WF LSBs with round-half-up (add 1<<(WF-1) before shift), then saturate to [0x8000, 0x7FFF] (defaults).
  - Any saturation sets the overflow flag.
  - Result is clip = (cx, cy, cz, cw); out_w <= cw.
- **DIV**: 3 sequential divisions, cx/cw, cy/cw, cz/cw.
  - Each division is a restoring sign-magnitude divider on |num|<<WF / |cw|.
  - One quotient bit per cycle, WI+2WF iterations (24 default).
  - Quotient truncates toward zero. Sign = sign(num) XOR sign(cw).
  - Quotient magnitude > max: saturate to 0x7FFF or 0x8000 by sign; set overflow.
  - cw == 0: quotient = 0x7FFF if num >= 0, else 0x8000; set overflow. The divider still spends its full iteration count, so latency is constant.
- **DONE**
  - out_valid=1; out_* and out_overflow stay stable until out_ready.
  - On handshake go IDLE.
- Reset (any state, including mid-MAC/DIV): state IDLE, in-flight vertex discarded, matrix register <= identity (diagonal 1<<WF, others 0).
- Reset values of outputs: in_ready=1, out_valid=0, busy=0, out_overflow=0, out_x/y/z/w=0.

## Timing
- Accept cycle = T0. MAC occupies T1..T16, NORM T17, DIV T18..T89. out_valid rises at T90 (defaults).
- General latency: 18 + 3*(WI+2WF) cycles to out_valid.
- No pipelining: one vertex in flight. in_ready=0 from T1 until the cycle after the out_valid handshake.
- Throughput (out_ready held 1): one vertex per 91 cycles.
- out_ready=1 at T90 returns to IDLE at T91. in_ready=1 at T91.
- Backpressure: out_valid holds, outputs unchanged, no new vertex accepted.
- mat_load and in_valid both high in IDLE: matrix loads, vertex waits one cycle and uses the new matrix.

## Test plan
- **Reset identity:** after rstn low, send vertex (0x0100, 0x0200, 0x0300) -> out_valid at T90, out = (0x0100, 0x0200, 0x0300), out_w=0x0100, out_overflow=0.
- **Projection:** load m0=m5=0x0200, m10=0x0100, m11=0xFF00, m14=0x0100, others 0; vertex (0x0100, 0x0100, 0x0200) -> clip (2.0, 2.0, 1.0, 2.0), out = (0x0100, 0x0100, 0x0080), out_w=0x0200.
- **Divide-by-zero:** load matrix with row 3 all zero, m0=0x0100; vertex x=0xFF00 -> out_x=0x8000, out_y=out_z=0x7FFF, out_w=0, out_overflow=1, still at T90.
- **Saturation:** identity with m0=0x7FFF; vertex x=0x7FFF -> NORM saturates cx to 0x7FFF, out_overflow=1.
- **Backpressure:** hold out_ready=0 for 10 cycles after T90 -> outputs stable, in_ready=0. Raise out_ready -> handshake; next vertex is accepted the following cycle.
- **Mid-operation control:**
  - Assert mat_load at T40 -> ignored; the result uses the old matrix.
  - Assert rstn=0 at T50 -> next cycle busy=0, out_valid=0, in_ready=1, matrix back to identity.
